// File: rtl/fft_axi_pkg.sv
// Shared types and constants for the FFT accelerator AXI initiator.
package fft_axi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StWaitCalc,
    StAr,
    StR,
    StDone
  } fft_mst_state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  SIZE_2B        = 3'd1;
  localparam logic [2:0]  SIZE_4B        = 3'd2;
  localparam int unsigned MAX_SAMPLES_WR = 2048;
  localparam int unsigned MAX_SAMPLES_RD = 1024;

endpackage

// File: rtl/axi_burst_planner.sv
// Burst planner shared by the write and read phases: burst length, start address, last-burst flag.
module axi_burst_planner #(
  parameter int unsigned MAX_BURST = 256,
  parameter logic [11:0] WR_BASE   = 12'h000,
  parameter logic [11:0] RD_BASE   = 12'h000
) (
  input  logic        is_read,
  input  logic [11:0] remaining,
  input  logic [11:0] index,
  output logic [7:0]  ax_len,
  output logic [8:0]  beats,
  output logic [11:0] addr,
  output logic        last_burst
);

  localparam logic [11:0] MaxBurst = 12'(MAX_BURST);

  always_comb begin
    last_burst = (remaining <= MaxBurst);
    beats      = last_burst ? remaining[8:0] : 9'(MAX_BURST);
    ax_len     = 8'(beats - 9'd1);
    // Samples are 2 bytes and results 4 bytes; the sum wraps modulo 4 KB.
    addr       = is_read ? RD_BASE + (index << 2) : WR_BASE + (index << 1);
  end

endmodule

// File: rtl/fft_axi_master.sv
// FFT accelerator AXI initiator: writes N samples in INCR bursts, waits for CALC_DONE, reads N results.
// Optional watchdog enabled by defining FFT_MST_TIMEOUT_EN.
module fft_axi_master
  import fft_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_W_WIDTH = 2,
  parameter int unsigned ID_R_WIDTH = 2,
  parameter int unsigned MAX_BURST  = 256,
  parameter logic [11:0] WR_BASE    = 12'h000,
  parameter logic [11:0] RD_BASE    = 12'h000,
  parameter int unsigned TXN_ID     = 0
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [11:0]           SAMP_NUMBER,
  input  logic                  CALC_DONE,
  input  logic [15:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [11:0]           AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic [ID_W_WIDTH-1:0] AWID,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [15:0]           WDATA,
  output logic [1:0]            WSTRB,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic                  BVALID,
  input  logic [ID_W_WIDTH-1:0] BID,
  output logic                  BREADY,
  output logic [11:0]           ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic [ID_R_WIDTH-1:0] ARID,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [ID_R_WIDTH-1:0] RID,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY
);

  fft_mst_state_t state_q, state_d;
  logic [11:0] n_q, n_d, remaining_q, remaining_d, index_q, index_d;
  logic [7:0]  beat_q, beat_d, len_q, len_d;
  logic        error_q, error_d;
  logic [7:0]  plan_len;
  logic [8:0]  plan_beats;
  logic [11:0] plan_addr;
  logic        plan_last;
  logic        final_beat;

  axi_burst_planner #(
    .MAX_BURST (MAX_BURST),
    .WR_BASE   (WR_BASE),
    .RD_BASE   (RD_BASE)
  ) u_planner (
    .is_read    ((state_q == StAr) || (state_q == StR)),
    .remaining  (remaining_q),
    .index      (index_q),
    .ax_len     (plan_len),
    .beats      (plan_beats),
    .addr       (plan_addr),
    .last_burst (plan_last)
  );

`ifdef FFT_MST_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        hs_any;
  assign hs_any = (AWVALID & AWREADY) | (WVALID & WREADY) | (BVALID & BREADY) |
                  (ARVALID & ARREADY) | (RVALID & RREADY);
`endif

  assign final_beat = (beat_q == len_q);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    beat_d      = beat_q;
    len_d       = len_q;
    error_d     = 1'b0;
    s_ready     = 1'b0;
    r_data      = '0;
    r_valid     = 1'b0;
    busy        = (state_q != StIdle) && (state_q != StDone);
    done        = (state_q == StDone);
    error       = error_q;
    AWADDR      = '0;
    AWLEN       = '0;
    AWSIZE      = '0;
    AWBURST     = '0;
    AWID        = '0;
    AWVALID     = 1'b0;
    WDATA       = '0;
    WSTRB       = '0;
    WVALID      = 1'b0;
    WLAST       = 1'b0;
    BREADY      = 1'b0;
    ARADDR      = '0;
    ARLEN       = '0;
    ARSIZE      = '0;
    ARBURST     = '0;
    ARID        = '0;
    ARVALID     = 1'b0;
    RREADY      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (SAMP_NUMBER == 12'd0 || SAMP_NUMBER > 12'(MAX_SAMPLES_WR)) begin
            error_d = 1'b1;
          end else begin
            n_d         = SAMP_NUMBER;
            remaining_d = SAMP_NUMBER;
            index_d     = '0;
            state_d     = StAw;
          end
        end
      end
      StAw: begin
        AWVALID = 1'b1;
        AWADDR  = plan_addr;
        AWLEN   = plan_len;
        AWSIZE  = SIZE_2B;
        AWBURST = AXI_BURST_INCR;
        AWID    = ID_W_WIDTH'(TXN_ID);
        if (AWREADY) begin
          len_d   = plan_len;
          beat_d  = '0;
          state_d = StW;
        end
      end
      StW: begin
        // Source stream is wired straight onto the W channel.
        WVALID  = s_valid;
        s_ready = WREADY;
        WDATA   = s_data;
        WSTRB   = 2'b11;
        WLAST   = final_beat;
        if (s_valid && WREADY) begin
          beat_d = beat_q + 8'd1;
          if (final_beat) state_d = StB;
        end
      end
      StB: begin
        BREADY = 1'b1;
        if (BVALID) begin
          if (BID != ID_W_WIDTH'(TXN_ID)) error_d = 1'b1;
          if (plan_last) begin
            remaining_d = n_q;
            index_d     = '0;
            state_d     = StWaitCalc;
          end else begin
            remaining_d = remaining_q - 12'(plan_beats);
            index_d     = index_q + 12'(plan_beats);
            state_d     = StAw;
          end
        end
      end
      StWaitCalc: begin
        // Results are 4 bytes each, so more than 1024 would overrun the 4 KB window.
        if (n_q > 12'(MAX_SAMPLES_RD)) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (CALC_DONE) begin
          state_d = StAr;
        end
      end
      StAr: begin
        ARVALID = 1'b1;
        ARADDR  = plan_addr;
        ARLEN   = plan_len;
        ARSIZE  = SIZE_4B;
        ARBURST = AXI_BURST_INCR;
        ARID    = ID_R_WIDTH'(TXN_ID);
        if (ARREADY) begin
          len_d   = plan_len;
          beat_d  = '0;
          state_d = StR;
        end
      end
      StR: begin
        r_data  = RDATA;
        r_valid = RVALID;
        RREADY  = r_ready;
        if (RVALID && r_ready) begin
          if (RID != ID_R_WIDTH'(TXN_ID) || RLAST != final_beat) error_d = 1'b1;
          beat_d = beat_q + 8'd1;
          if (final_beat) begin
            if (plan_last) begin
              state_d = StDone;
            end else begin
              remaining_d = remaining_q - 12'(plan_beats);
              index_d     = index_q + 12'(plan_beats);
              state_d     = StAr;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef FFT_MST_TIMEOUT_EN
    if (busy && wdog_q == 16'hFFFF) begin
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      s_ready = 1'b0;
      BREADY  = 1'b0;
      ARVALID = 1'b0;
      RREADY  = 1'b0;
      r_valid = 1'b0;
      error_d = 1'b1;
      state_d = StIdle;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      n_q         <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      error_q     <= error_d;
    end
  end

`ifdef FFT_MST_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (Reset || state_d != state_q || hs_any) begin
      wdog_q <= '0;
    end else if (busy) begin
      wdog_q <= wdog_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_axi_master.sv
// Directed bench for fft_axi_master with a behavioural AXI slave, sample source and result sink.
`timescale 1ns/1ps
module tb_fft_axi_master;

  logic        clk = 1'b0;
  logic        Reset, start, CALC_DONE;
  logic [11:0] SAMP_NUMBER;
  logic [15:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] r_data;
  logic        r_valid, r_ready;
  logic        busy, done, error;
  logic [11:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, AWID, ARID, BID, RID, WSTRB;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
  logic [15:0] WDATA;
  logic [31:0] RDATA;

  always #5 clk = ~clk;

  fft_axi_master dut (
    .clk(clk), .Reset(Reset), .start(start), .SAMP_NUMBER(SAMP_NUMBER), .CALC_DONE(CALC_DONE),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .busy(busy), .done(done), .error(error),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BVALID(BVALID), .BID(BID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RID(RID), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave / source / sink model state
  bit          stall_en, bad_rlast, calc_done_v;
  int          src_idx, n_cur, rd_idx;
  logic [19:0] aw_log[$], ar_log[$];
  logic [15:0] wdata_log[$];
  logic [31:0] rdata_log[$];
  logic [6:0]  aw_attr, ar_attr;
  logic [7:0]  cur_awlen, cur_arlen;
  int          w_beat, r_beat, r_left, b_pend, b_cnt;
  int          proto_err, stab_err, done_cnt, err_cnt, awv_seen, busy_seen;
  logic        pv_aw, pv_ar;
  logic [19:0] p_aw, p_ar;

  always @(negedge clk) begin
    if (Reset) begin
      s_valid = 0; AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
      RLAST = 0; r_ready = 0; b_pend = 0; r_left = 0; pv_aw = 0; pv_ar = 0;
    end else begin
      AWREADY = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      WREADY  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = (src_idx < n_cur) && (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
      s_data  = 16'(src_idx + 1);
      BVALID  = (b_pend > 0);
      ARREADY = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      RVALID  = (r_left > 0) && (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
      RDATA   = 32'hC0DE_0000 + 32'(rd_idx);
      RLAST   = (r_beat == int'(cur_arlen)) || (bad_rlast && r_beat == 1);
      r_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    CALC_DONE = calc_done_v;
    BID = 2'd0;
    RID = 2'd0;
    #1;
    if (AWVALID) awv_seen++;
    if (busy) busy_seen++;
    if (done) done_cnt++;
    if (error) err_cnt++;
    // Address/length must hold while VALID waits for READY
    if (pv_aw && {AWVALID, AWADDR, AWLEN} != {1'b1, p_aw}) stab_err++;
    if (pv_ar && {ARVALID, ARADDR, ARLEN} != {1'b1, p_ar}) stab_err++;
    pv_aw = AWVALID && !AWREADY;
    p_aw  = {AWADDR, AWLEN};
    pv_ar = ARVALID && !ARREADY;
    p_ar  = {ARADDR, ARLEN};
    if (AWVALID && AWREADY) begin
      aw_log.push_back({AWADDR, AWLEN});
      aw_attr   = {AWSIZE, AWBURST, AWID};
      cur_awlen = AWLEN;
      w_beat    = 0;
    end
    if ((s_valid && s_ready) !== (WVALID && WREADY)) proto_err++;
    if (WVALID && WREADY) begin
      wdata_log.push_back(WDATA);
      if (WLAST !== (w_beat == int'(cur_awlen)) || WSTRB !== 2'b11) proto_err++;
      if (w_beat == int'(cur_awlen)) b_pend++;
      w_beat++;
      src_idx++;
    end
    if (BVALID && BREADY) begin
      b_pend--;
      b_cnt++;
    end
    if (ARVALID && ARREADY) begin
      ar_log.push_back({ARADDR, ARLEN});
      ar_attr   = {ARSIZE, ARBURST, ARID};
      cur_arlen = ARLEN;
      r_left    = int'(ARLEN) + 1;
      r_beat    = 0;
    end
    if ((r_valid && r_ready) !== (RVALID && RREADY)) proto_err++;
    if (r_valid && r_ready) rdata_log.push_back(r_data);
    if (RVALID && RREADY) begin
      r_left--;
      r_beat++;
      rd_idx++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [19:0] q_at(input logic [19:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 20'hFFFFF;
  endfunction

  task automatic prep(input int n, input bit pre_calc, input bit stall, input bit badr);
    aw_log.delete(); ar_log.delete(); wdata_log.delete(); rdata_log.delete();
    src_idx = 0; n_cur = n; rd_idx = 0; b_cnt = 0; proto_err = 0; stab_err = 0;
    stall_en = stall; bad_rlast = badr; calc_done_v = pre_calc;
  endtask

  task automatic run(input string tag, input int n, input bit pre_calc, input bit stall,
                     input bit badr, input int exp_err);
    int bursts, cyc, d0, e0;
    bit got_done;
    bursts = (n + 255) / 256;
    cyc = 0;
    prep(n, pre_calc, stall, badr);
    d0 = done_cnt;
    e0 = err_cnt;
    SAMP_NUMBER = 12'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (b_cnt < bursts && cyc < 20000) begin tick(); cyc++; end
    if (!pre_calc) begin
      repeat (4) tick();
      check_eq({tag, "_hold_no_ar"}, 32'(ar_log.size()), 0);
      check_eq({tag, "_busy_wait"}, 32'(busy), 1);
      calc_done_v = 1'b1;
    end
    while (done_cnt == d0 && cyc < 20000) begin tick(); cyc++; end
    got_done = (done_cnt != d0);
    repeat (3) tick();
    check_eq({tag, "_done_pulse"}, 32'(done_cnt - d0), 1);
    check_eq({tag, "_idle_after"}, 32'(busy), 0);
    check_eq({tag, "_errors"}, 32'(err_cnt - e0), 32'(exp_err));
    if (!got_done) $display("FAIL %s_timeout: got no done expected done", tag);
  endtask

  task automatic check_streams(input string tag, input int n);
    int wbad, rbad;
    wbad = 0;
    rbad = 0;
    foreach (wdata_log[i]) if (wdata_log[i] !== 16'(i + 1)) wbad++;
    foreach (rdata_log[i]) if (rdata_log[i] !== 32'hC0DE_0000 + 32'(i)) rbad++;
    check_eq({tag, "_wcount"}, 32'(wdata_log.size()), 32'(n));
    check_eq({tag, "_wdata"}, 32'(wbad), 0);
    check_eq({tag, "_rcount"}, 32'(rdata_log.size()), 32'(n));
    check_eq({tag, "_rdata"}, 32'(rbad), 0);
    check_eq({tag, "_proto"}, 32'(proto_err), 0);
    check_eq({tag, "_stable"}, 32'(stab_err), 0);
  endtask

  task automatic bad_start(input string tag, input int n);
    int e0, a0, b0;
    e0 = err_cnt;
    a0 = awv_seen;
    b0 = busy_seen;
    SAMP_NUMBER = 12'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check_eq({tag, "_err"}, 32'(err_cnt - e0), 1);
    check_eq({tag, "_no_aw"}, 32'(awv_seen - a0), 0);
    check_eq({tag, "_no_busy"}, 32'(busy_seen - b0), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"}, 32'({AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, s_ready,
                                 r_valid, busy, done, error}), 0);
    check_eq({tag, "_addr"}, 32'({AWADDR, AWLEN, ARLEN}), 0);
    check_eq({tag, "_data"}, {WDATA, WSTRB, ARADDR[11:0], 2'b00}, 0);
    check_eq({tag, "_rdata"}, r_data, 0);
  endtask

  initial begin
    int cyc;
    Reset = 1'b1; start = 1'b0; SAMP_NUMBER = '0; calc_done_v = 1'b0;
    n_cur = 0; src_idx = 0; done_cnt = 0; err_cnt = 0; awv_seen = 0; busy_seen = 0;
    cur_awlen = '0; cur_arlen = '0; r_beat = 0; w_beat = 0; rd_idx = 0;
    repeat (3) tick();
    check_reset_outs("reset");
    Reset = 1'b0;
    tick();

    bad_start("n0", 0);
    bad_start("n2049", 2049);

    run("n4", 4, 1'b0, 1'b0, 1'b0, 0);
    check_eq("n4_aw_cnt", 32'(aw_log.size()), 1);
    check_eq("n4_aw0", 32'(q_at(aw_log, 0)), 32'({12'h000, 8'd3}));
    check_eq("n4_aw_attr", 32'(aw_attr), 32'({3'd1, 2'b01, 2'd0}));
    check_eq("n4_ar_cnt", 32'(ar_log.size()), 1);
    check_eq("n4_ar0", 32'(q_at(ar_log, 0)), 32'({12'h000, 8'd3}));
    check_eq("n4_ar_attr", 32'(ar_attr), 32'({3'd2, 2'b01, 2'd0}));
    check_streams("n4", 4);

    run("n300", 300, 1'b0, 1'b0, 1'b0, 0);
    check_eq("n300_aw_cnt", 32'(aw_log.size()), 2);
    check_eq("n300_aw0", 32'(q_at(aw_log, 0)), 32'({12'h000, 8'hFF}));
    check_eq("n300_aw1", 32'(q_at(aw_log, 1)), 32'({12'h200, 8'h2B}));
    check_eq("n300_ar_cnt", 32'(ar_log.size()), 2);
    check_eq("n300_ar0", 32'(q_at(ar_log, 0)), 32'({12'h000, 8'hFF}));
    check_eq("n300_ar1", 32'(q_at(ar_log, 1)), 32'({12'h400, 8'h2B}));
    check_streams("n300", 300);

    run("n16stall", 16, 1'b1, 1'b1, 1'b0, 0);
    check_eq("n16_aw0", 32'(q_at(aw_log, 0)), 32'({12'h000, 8'd15}));
    check_eq("n16_ar0", 32'(q_at(ar_log, 0)), 32'({12'h000, 8'd15}));
    check_streams("n16stall", 16);

    // RLAST on beats 2 and 4 of a 4-beat read: only the early one is a protocol error
    run("rlast_early", 4, 1'b1, 1'b0, 1'b1, 1);
    bad_rlast = 1'b0;

    // Reset while the write burst is in flight
    prep(8, 1'b1, 1'b0, 1'b0);
    SAMP_NUMBER = 12'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (wdata_log.size() < 2 && cyc < 100) begin tick(); cyc++; end
    check_eq("midw_beats", 32'(wdata_log.size()), 2);
    Reset = 1'b1;
    tick();
    check_reset_outs("midw_rst");
    Reset = 1'b0;
    tick();
    run("after_rst", 4, 1'b1, 1'b0, 1'b0, 0);
    check_eq("after_rst_aw0", 32'(q_at(aw_log, 0)), 32'({12'h000, 8'd3}));
    check_streams("after_rst", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
